int_issue_queue: RTL

- Integer issue queue directly downstream of the dispatch stage; consumes to_iq_instr0_* and drives iq_can_alloc0 back to it.
- Holds renamed micro-ops until both physical sources are ready, then issues the oldest ready entry (by ROB index age) to one ALU/MUL pipe.
- Wakes sources from writeback broadcasts and squashes entries younger than a redirect.

---
 rtl/int_issue_queue.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/int_issue_queue.sv
// Integer issue queue: holds renamed micro-ops until both sources are ready,
// then issues the oldest ready entry (ROB age order) to a single pipe.
module int_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned ROB_W     = 6,
  parameter int unsigned PAYLOAD_W = 128
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enq_valid,
  output logic                 iq_can_alloc,
  input  logic [PREG_W-1:0]    enq_prs1,
  input  logic [PREG_W-1:0]    enq_prs2,
  input  logic [PREG_W-1:0]    enq_prd,
  input  logic                 enq_src1_is_reg,
  input  logic                 enq_src2_is_reg,
  input  logic                 enq_src1_busy,
  input  logic                 enq_src2_busy,
  input  logic                 enq_robidx_flag,
  input  logic [ROB_W-1:0]     enq_robidx,
  input  logic [PAYLOAD_W-1:0] enq_payload,
  input  logic                 wb0_valid,
  input  logic [PREG_W-1:0]    wb0_prd,
  input  logic                 wb1_valid,
  input  logic [PREG_W-1:0]    wb1_prd,
  input  logic                 flush_valid,
  input  logic                 flush_robidx_flag,
  input  logic [ROB_W-1:0]     flush_robidx,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [PREG_W-1:0]    issue_prs1,
  output logic [PREG_W-1:0]    issue_prs2,
  output logic [PREG_W-1:0]    issue_prd,
  output logic                 issue_src1_is_reg,
  output logic                 issue_src2_is_reg,
  output logic                 issue_robidx_flag,
  output logic [ROB_W-1:0]     issue_robidx,
  output logic [PAYLOAD_W-1:0] issue_payload
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [PREG_W-1:0]    prd;
    logic                 src1_is_reg;
    logic                 src2_is_reg;
    logic                 rob_flag;
    logic [ROB_W-1:0]     rob_idx;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             enq_fire;
  logic             issue_fire;
  logic             enq_rdy1;
  logic             enq_rdy2;

  // A is older than B; the wrap flag inverts the index comparison
  function automatic logic older(input logic fa, input logic [ROB_W-1:0] ia,
                                 input logic fb, input logic [ROB_W-1:0] ib);
    older = (fa == fb) ? (ia < ib) : (ia > ib);
  endfunction

  // Oldest valid entry whose sources are both ready
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        if (!sel_found ||
            older(entry_q[i].rob_flag, entry_q[i].rob_idx,
                  entry_q[sel_idx].rob_flag, entry_q[sel_idx].rob_idx)) begin
          sel_found = 1'b1;
          sel_idx   = i[IDX_W-1:0];
        end
      end
    end
  end

  // Lowest-numbered free entry
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
    end
  end

  assign iq_can_alloc = ~&valid_q;
  assign issue_valid  = sel_found & ~flush_valid;
  assign enq_fire     = enq_valid & iq_can_alloc & ~flush_valid;
  assign issue_fire   = issue_valid & issue_ready;

  // Dispatch-time readiness including same-cycle writeback bypass
  assign enq_rdy1 = ~enq_src1_is_reg | ~enq_src1_busy |
                    (wb0_valid & (wb0_prd == enq_prs1)) |
                    (wb1_valid & (wb1_prd == enq_prs1));
  assign enq_rdy2 = ~enq_src2_is_reg | ~enq_src2_busy |
                    (wb0_valid & (wb0_prd == enq_prs2)) |
                    (wb1_valid & (wb1_prd == enq_prs2));

  // Issue outputs follow the selected entry, zero when nothing is selectable
  always_comb begin
    issue_prs1        = '0;
    issue_prs2        = '0;
    issue_prd         = '0;
    issue_src1_is_reg = 1'b0;
    issue_src2_is_reg = 1'b0;
    issue_robidx_flag = 1'b0;
    issue_robidx      = '0;
    issue_payload     = '0;
    if (sel_found) begin
      issue_prs1        = entry_q[sel_idx].prs1;
      issue_prs2        = entry_q[sel_idx].prs2;
      issue_prd         = entry_q[sel_idx].prd;
      issue_src1_is_reg = entry_q[sel_idx].src1_is_reg;
      issue_src2_is_reg = entry_q[sel_idx].src2_is_reg;
      issue_robidx_flag = entry_q[sel_idx].rob_flag;
      issue_robidx      = entry_q[sel_idx].rob_idx;
      issue_payload     = entry_q[sel_idx].payload;
    end
  end

  // Next state: wakeup, flush squash, issue clear, then enqueue write.
  // The enqueue slot is always a currently-free entry, so it never collides
  // with the issue clear or the flush squash.
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    entry_d = entry_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((wb0_valid && (wb0_prd == entry_q[i].prs1)) ||
          (wb1_valid && (wb1_prd == entry_q[i].prs1))) begin
        rdy1_d[i] = 1'b1;
      end
      if ((wb0_valid && (wb0_prd == entry_q[i].prs2)) ||
          (wb1_valid && (wb1_prd == entry_q[i].prs2))) begin
        rdy2_d[i] = 1'b1;
      end
      if (flush_valid && valid_q[i] &&
          older(flush_robidx_flag, flush_robidx,
                entry_q[i].rob_flag, entry_q[i].rob_idx)) begin
        valid_d[i] = 1'b0;
      end
    end
    if (issue_fire) begin
      valid_d[sel_idx] = 1'b0;
    end
    if (enq_fire) begin
      valid_d[free_idx]             = 1'b1;
      rdy1_d[free_idx]              = enq_rdy1;
      rdy2_d[free_idx]              = enq_rdy2;
      entry_d[free_idx].prs1        = enq_prs1;
      entry_d[free_idx].prs2        = enq_prs2;
      entry_d[free_idx].prd         = enq_prd;
      entry_d[free_idx].src1_is_reg = enq_src1_is_reg;
      entry_d[free_idx].src2_is_reg = enq_src2_is_reg;
      entry_d[free_idx].rob_flag    = enq_robidx_flag;
      entry_d[free_idx].rob_idx     = enq_robidx;
      entry_d[free_idx].payload     = enq_payload;
    end
  end

  // Valid bits: the only state that reset must clear
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Entry contents and ready bits, qualified by valid_q everywhere
  always_ff @(posedge clock) begin
    rdy1_q  <= rdy1_d;
    rdy2_q  <= rdy2_d;
    entry_q <= entry_d;
  end

endmodule
